// File: rtl/wt_time_ctrl_pkg.sv
// Shared encodings and field limits for the wall-time controller.
package wt_time_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_SET_H = 2'd1,
    MODE_SET_M = 2'd2,
    MODE_SET_S = 2'd3
  } mode_e;

  localparam int FIELD_W  = 6;
  localparam int HOUR_W   = 5;
  localparam int DIGIT_W  = 4;

  localparam logic [FIELD_W-1:0] SEC_MAX    = 6'd59;
  localparam logic [FIELD_W-1:0] MIN_MAX    = 6'd59;
  localparam logic [HOUR_W-1:0]  HOUR24_MAX = 5'd23;
  localparam logic [HOUR_W-1:0]  HOUR12_MAX = 5'd12;

  function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] v,
                                                  input logic [FIELD_W-1:0] max);
    return (v == max) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/wt_digit_split.sv
// Combinational tens/ones split of a 0..59 field.
module wt_digit_split
  import wt_time_ctrl_pkg::*;
(
  input  logic [FIELD_W-1:0] val_i,
  output logic [DIGIT_W-1:0] tens_o,
  output logic [DIGIT_W-1:0] ones_o
);

  always_comb begin
    tens_o = DIGIT_W'(val_i / FIELD_W'(10));
    ones_o = DIGIT_W'(val_i % FIELD_W'(10));
  end

endmodule

// File: rtl/wt_time_ctrl.sv
// Wall-time controller: prescaler, mode FSM, H/M/S counters, decimal digits.
// Define WT_24H_EN for the 24-hour build; default is the 12-hour build with PM flag.
module wt_time_ctrl
  import wt_time_ctrl_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                MODE_BTN,
  input  logic                UP_BTN,
  output logic [HOUR_W-1:0]   HOUR,
  output logic [FIELD_W-1:0]  MIN,
  output logic [FIELD_W-1:0]  SEC,
  output logic [DIGIT_W-1:0]  H10,
  output logic [DIGIT_W-1:0]  H1,
  output logic [DIGIT_W-1:0]  M10,
  output logic [DIGIT_W-1:0]  M1,
  output logic [DIGIT_W-1:0]  S10,
  output logic [DIGIT_W-1:0]  S1,
  output logic [1:0]          MODE,
  output logic                PM,
  output logic                SEC_PULSE
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
`ifdef WT_24H_EN
  localparam logic [HOUR_W-1:0] HOUR_RST = '0;
`else
  localparam logic [HOUR_W-1:0] HOUR_RST = HOUR12_MAX;
`endif

  mode_e              mode_q, mode_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [HOUR_W-1:0]  hour_q, hour_d;
  logic [FIELD_W-1:0] min_q, min_d, sec_q, sec_d;
  logic               pm_q, pm_d;
  logic               pulse_q;
  logic               tick, up, hour_inc;

  always_comb begin
    tick     = (mode_q == MODE_RUN) && (presc_q == PRESC_LAST);
    // a mode change swallows a coincident UP press
    up       = UP_BTN && !MODE_BTN;
    mode_d   = MODE_BTN ? mode_e'(mode_q + 2'd1) : mode_q;
    presc_d  = (mode_q != MODE_RUN || MODE_BTN || tick) ? '0 : presc_q + 1'b1;
    sec_d    = sec_q;
    min_d    = min_q;
    hour_d   = hour_q;
    pm_d     = pm_q;
    hour_inc = 1'b0;

    if (tick) begin
      sec_d = wrap_inc(sec_q, SEC_MAX);
      if (sec_q == SEC_MAX) begin
        min_d    = wrap_inc(min_q, MIN_MAX);
        hour_inc = (min_q == MIN_MAX);
      end
    end else if (up) begin
      case (mode_q)
        MODE_SET_H: hour_inc = 1'b1;
        MODE_SET_M: min_d    = wrap_inc(min_q, MIN_MAX);
        MODE_SET_S: sec_d    = wrap_inc(sec_q, SEC_MAX);
        default:    ;
      endcase
    end

    if (hour_inc) begin
`ifdef WT_24H_EN
      hour_d = (hour_q == HOUR24_MAX) ? '0 : hour_q + 1'b1;
`else
      hour_d = (hour_q == HOUR12_MAX) ? 5'd1 : hour_q + 1'b1;
      pm_d   = pm_q ^ (hour_q == 5'd11);
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mode_q  <= MODE_RUN;
      presc_q <= '0;
      hour_q  <= HOUR_RST;
      min_q   <= '0;
      sec_q   <= '0;
      pm_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      presc_q <= presc_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      pm_q    <= pm_d;
      pulse_q <= tick;
    end
  end

  assign HOUR      = hour_q;
  assign MIN       = min_q;
  assign SEC       = sec_q;
  assign MODE      = mode_q;
  assign PM        = pm_q;
  assign SEC_PULSE = pulse_q;

  wt_digit_split u_split_h (.val_i({1'b0, hour_q}), .tens_o(H10), .ones_o(H1));
  wt_digit_split u_split_m (.val_i(min_q),          .tens_o(M10), .ones_o(M1));
  wt_digit_split u_split_s (.val_i(sec_q),          .tens_o(S10), .ones_o(S1));

endmodule

// File: tb/tb_wt_time_ctrl.sv
// Randomized + directed bench for wt_time_ctrl against a seconds-of-day style model.
module tb_wt_time_ctrl;

  localparam int TPS = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1, MODE_BTN = 1'b0, UP_BTN = 1'b0;
  logic [4:0] HOUR;
  logic [5:0] MIN, SEC;
  logic [3:0] H10, H1, M10, M1, S10, S1;
  logic [1:0] MODE;
  logic       PM, SEC_PULSE;

  wt_time_ctrl #(.TICKS_PER_SEC(TPS)) dut (
    .CLK(CLK), .RESET(RESET), .MODE_BTN(MODE_BTN), .UP_BTN(UP_BTN),
    .HOUR(HOUR), .MIN(MIN), .SEC(SEC),
    .H10(H10), .H1(H1), .M10(M10), .M1(M1), .S10(S10), .S1(S1),
    .MODE(MODE), .PM(PM), .SEC_PULSE(SEC_PULSE)
  );

  always #5 CLK = ~CLK;

  int total = 0, bad = 0;
  // model: h24 is 0..23 hour of day, cnt counts RUN cycles since last tick/entry
  int m_mode = 0, m_cnt = 0, m_h = 0, m_m = 0, m_s = 0, m_pulse = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_hour();
`ifdef WT_24H_EN
    return m_h;
`else
    return (m_h % 12 == 0) ? 12 : m_h % 12;
`endif
  endfunction

  function automatic int exp_pm();
`ifdef WT_24H_EN
    return 0;
`else
    return (m_h >= 12) ? 1 : 0;
`endif
  endfunction

  task automatic model_step(input logic mb, input logic ub, input logic rst);
    bit tk;
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_h = 0; m_m = 0; m_s = 0; m_pulse = 0;
      return;
    end
    tk = (m_mode == 0) && (m_cnt == TPS - 1);
    m_pulse = tk;
    if (tk) begin
      m_s++;
      if (m_s == 60) begin
        m_s = 0; m_m++;
        if (m_m == 60) begin m_m = 0; m_h = (m_h + 1) % 24; end
      end
    end
    m_cnt = (m_mode == 0 && !tk) ? m_cnt + 1 : 0;
    if (ub && !mb) begin
      case (m_mode)
        1: m_h = (m_h + 1) % 24;
        2: m_m = (m_m + 1) % 60;
        3: m_s = (m_s + 1) % 60;
        default: ;
      endcase
    end
    if (mb) m_mode = (m_mode + 1) % 4;
  endtask

  task automatic check_all();
    chk("hour", HOUR, exp_hour());
    chk("min", MIN, m_m);
    chk("sec", SEC, m_s);
    chk("h10", H10, exp_hour() / 10);
    chk("h1", H1, exp_hour() % 10);
    chk("m10", M10, m_m / 10);
    chk("m1", M1, m_m % 10);
    chk("s10", S10, m_s / 10);
    chk("s1", S1, m_s % 10);
    chk("mode", MODE, m_mode);
    chk("pm", PM, exp_pm());
    chk("sec_pulse", SEC_PULSE, m_pulse);
  endtask

  task automatic cyc(input logic mb, input logic ub, input logic rst);
    MODE_BTN = mb; UP_BTN = ub; RESET = rst;
    @(posedge CLK);
    model_step(mb, ub, rst);
    #1;
    check_all();
    MODE_BTN = 1'b0; UP_BTN = 1'b0; RESET = 1'b0;
  endtask

  // drive fields to h24:m:s through the set modes, ending back in RUN
  task automatic set_to(input int h, input int mi, input int s);
    int n;
    n = 0;
    while (m_mode != 0 && n < 4) begin cyc(1, 0, 0); n++; end
    cyc(1, 0, 0);
    n = 0;
    while (m_h != h && n < 30) begin cyc(0, 1, 0); n++; end
    if (m_h != h) chk("set_h_timeout", 1, 0);
    cyc(1, 0, 0);
    n = 0;
    while (m_m != mi && n < 70) begin cyc(0, 1, 0); n++; end
    if (m_m != mi) chk("set_m_timeout", 1, 0);
    cyc(1, 0, 0);
    n = 0;
    while (m_s != s && n < 70) begin cyc(0, 1, 0); n++; end
    if (m_s != s) chk("set_s_timeout", 1, 0);
    cyc(1, 0, 0);
  endtask

  initial begin
    int npulse, first, last, hsave, ssave, n;

    // reset state
    cyc(0, 0, 1);
    cyc(0, 0, 1);
`ifdef WT_24H_EN
    chk("rst_hour", HOUR, 0);
`else
    chk("rst_hour", HOUR, 12);
`endif
    chk("rst_mode", MODE, 0);
    chk("rst_pulse", SEC_PULSE, 0);

    // 12 cycles in RUN: three pulses, 4 apart, first after edge 4
    npulse = 0; first = -1; last = -1;
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 0, 0);
      if (SEC_PULSE) begin
        if (first < 0) first = i;
        else chk("pulse_spacing", i - last, 4);
        last = i;
        npulse++;
      end
    end
    chk("run12_sec", SEC, 3);
    chk("run12_npulse", npulse, 3);
    chk("run12_first", first, 4);

    // full rollover 23:59:59 -> midnight
    set_to(23, 59, 59);
    for (int i = 0; i < TPS; i++) cyc(0, 0, 0);
`ifdef WT_24H_EN
    chk("roll_hour", HOUR, 0);
    chk("roll_h1", H1, 0);
`else
    chk("roll_hour", HOUR, 12);
    chk("roll_pm", PM, 0);
`endif
    chk("roll_min", MIN, 0);
    chk("roll_sec", SEC, 0);
    chk("roll_digits", {M10, M1, S10, S1}, 0);

    // 11:59:59 -> 12:00:00, then 12:59:59 -> 13:00:00
    set_to(11, 59, 59);
    chk("pre_noon_pm", PM, 0);
    for (int i = 0; i < TPS; i++) cyc(0, 0, 0);
    chk("noon_hour", HOUR, 12);
    chk("noon_h10", H10, 1);
    chk("noon_h1", H1, 2);
`ifdef WT_24H_EN
    chk("noon_pm", PM, 0);
`else
    chk("noon_pm", PM, 1);
`endif
    set_to(12, 59, 59);
    for (int i = 0; i < TPS; i++) cyc(0, 0, 0);
`ifdef WT_24H_EN
    chk("pm1_hour", HOUR, 13);
`else
    chk("pm1_hour", HOUR, 1);
    chk("pm1_pm", PM, 1);
`endif

    // SET_M wrap with no carry, then MODE+UP together
    set_to(5, 59, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    hsave = HOUR;
    cyc(0, 1, 0);
    chk("setm_wrap_min", MIN, 0);
    chk("setm_wrap_hour", HOUR, hsave);
    cyc(1, 1, 0);
    chk("mode_up_mode", MODE, 3);
    chk("mode_up_min", MIN, 0);

    // frozen in SET_S
    ssave = SEC;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0);
      chk("sets_sec_frozen", SEC, ssave);
      chk("sets_no_pulse", SEC_PULSE, 0);
    end
    cyc(1, 0, 0);
    for (int i = 0; i < TPS; i++) cyc(0, 0, 0);
    chk("resume_first_tick", SEC, (ssave + 1) % 60);

    // reset overrides UP in SET_H
    cyc(1, 0, 0);
    chk("in_set_h", MODE, 1);
    cyc(0, 1, 1);
    chk("rst_sethmode", MODE, 0);
    chk("rst_seth_sec", SEC, 0);
    chk("rst_seth_min", MIN, 0);

    // tick coincident with MODE at SEC=9
    n = 0;
    while (!(m_s == 9 && m_cnt == TPS - 1) && n < 100) begin cyc(0, 0, 0); n++; end
    if (n >= 100) chk("tick_mode_timeout", 1, 0);
    cyc(1, 0, 0);
    chk("tm_sec", SEC, 10);
    chk("tm_s10", S10, 1);
    chk("tm_s1", S1, 0);
    chk("tm_mode", MODE, 1);

    // random phase
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(15) == 0, $urandom_range(3) == 0, $urandom_range(299) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
